// File: rtl/nr4sdp_pkg.sv
// Shared constants, the signed digit type and digit/bit-pair helpers for the NR4SD+ recoder.
package nr4sdp_pkg;

  localparam int N_BITS   = 8;
  localparam int N_DIGITS = 3;
  localparam int COR_W    = 16;

  typedef logic signed [2:0] digit_t;

  // NR4SD+ bit pair {np, nm}; the digit value is 2*np - nm.
  function automatic logic [1:0] digit_to_bits(input digit_t d);
    logic [1:0] bits;
    case (d)
      3'b001:  bits = 2'b11;
      3'b010:  bits = 2'b10;
      3'b111:  bits = 2'b01;
      default: bits = 2'b00;
    endcase
    return bits;
  endfunction

  function automatic digit_t bits_to_digit(input logic np, input logic nm);
    digit_t d;
    d = digit_t'({1'b0, np, 1'b0}) - digit_t'({2'b00, nm});
    return d;
  endfunction

endpackage

// File: rtl/nr4sdp_recoder_unit_digit_cell.sv
// Combinational NR4SD+ digit cell: one radix-4 slice of the operand plus incoming carry
// becomes a digit in {-1,0,+1,+2}, its select lines and the outgoing carry.
module nr4sdp_digit_cell
  import nr4sdp_pkg::*;
(
  input  logic a_hi,
  input  logic a_lo,
  input  logic c_in,
  output logic np,
  output logic nm,
  output logic one_p,
  output logic one_m,
  output logic two_p,
  output logic c_out
);

  logic [2:0] v;
  digit_t     y;
  logic [1:0] bits;

  // v = 2*a_hi + a_lo + c_in; values 3 and 4 are folded back by carrying one radix-4 unit.
  always_comb begin
    v     = {1'b0, a_hi, 1'b0} + {2'b00, a_lo} + {2'b00, c_in};
    y     = '0;
    c_out = 1'b0;
    case (v)
      3'd1: y = 3'sb001;
      3'd2: y = 3'sb010;
      3'd3: begin
        y     = 3'sb111;
        c_out = 1'b1;
      end
      3'd4: c_out = 1'b1;
      default: y = '0;
    endcase
  end

  assign bits  = digit_to_bits(y);
  assign np    = bits[1];
  assign nm    = bits[0];
  assign one_p = np & nm;
  assign one_m = ~np & nm;
  assign two_p = np & ~nm;

endmodule

// File: rtl/nr4sdp_recoder_unit.sv
// Registered NR4SD+ recoder front end for the 8x8 signed multiplier (1-cycle latency).
// Optional macro NR4SDP_DIGIT_VALUE_EN adds the 12-bit packed digit-value output 'digits'.
module nr4sdp_recoder_unit
  import nr4sdp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [N_BITS-1:0]   a,
  output logic                out_valid,
  output logic [N_DIGITS-1:0] nm,
  output logic [N_DIGITS-1:0] np,
  output logic [N_DIGITS-1:0] one_p,
  output logic [N_DIGITS-1:0] one_m,
  output logic [N_DIGITS-1:0] two_p,
  output logic                sign,
  output logic                one,
  output logic                two,
  output logic [COR_W-1:0]    cor
`ifdef NR4SDP_DIGIT_VALUE_EN
  ,
  output logic [11:0]         digits
`endif
);

  // ---- stage p0: combinational recoding of a ----
  logic [N_DIGITS:0]   c_p0;
  logic [N_DIGITS-1:0] np_p0, nm_p0, one_p_p0, one_m_p0, two_p_p0;
  digit_t              y3_p0;
  logic                sign_p0, one_p0, two_p0;
  logic [COR_W-1:0]    cor_p0;

  assign c_p0[0] = 1'b0;

  for (genvar j = 0; j < N_DIGITS; j++) begin : g_digit
    nr4sdp_digit_cell u_cell (
      .a_hi  (a[2*j+1]),
      .a_lo  (a[2*j]),
      .c_in  (c_p0[j]),
      .np    (np_p0[j]),
      .nm    (nm_p0[j]),
      .one_p (one_p_p0[j]),
      .one_m (one_m_p0[j]),
      .two_p (two_p_p0[j]),
      .c_out (c_p0[j+1])
    );
  end

  // MB most-significant digit: -2*a7 + a6 + c3 always fits in 3-bit two's complement.
  assign y3_p0   = digit_t'({a[7], a[7], 1'b0}) + digit_t'({2'b00, a[6]})
                 + digit_t'({2'b00, c_p0[N_DIGITS]});
  assign sign_p0 = y3_p0[2];
  assign one_p0  = (y3_p0 == 3'sb001) || (y3_p0 == 3'sb111);
  assign two_p0  = (y3_p0 == 3'sb010) || (y3_p0 == 3'sb110);

  always_comb begin
    cor_p0    = '0;
    cor_p0[0] = one_m_p0[0];
    cor_p0[2] = one_m_p0[1];
    cor_p0[4] = one_m_p0[2];
    cor_p0[6] = sign_p0 & (one_p0 | two_p0);
  end

  // ---- stage p1: output register ----
  logic                vld_p1;
  logic [N_DIGITS-1:0] np_p1, nm_p1, one_p_p1, one_m_p1, two_p_p1;
  logic                sign_p1, one_p1, two_p1;
  logic [COR_W-1:0]    cor_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      np_p1    <= '0;
      nm_p1    <= '0;
      one_p_p1 <= '0;
      one_m_p1 <= '0;
      two_p_p1 <= '0;
      sign_p1  <= 1'b0;
      one_p1   <= 1'b0;
      two_p1   <= 1'b0;
      cor_p1   <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        np_p1    <= np_p0;
        nm_p1    <= nm_p0;
        one_p_p1 <= one_p_p0;
        one_m_p1 <= one_m_p0;
        two_p_p1 <= two_p_p0;
        sign_p1  <= sign_p0;
        one_p1   <= one_p0;
        two_p1   <= two_p0;
        cor_p1   <= cor_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign np        = np_p1;
  assign nm        = nm_p1;
  assign one_p     = one_p_p1;
  assign one_m     = one_m_p1;
  assign two_p     = two_p_p1;
  assign sign      = sign_p1;
  assign one       = one_p1;
  assign two       = two_p1;
  assign cor       = cor_p1;

`ifdef NR4SDP_DIGIT_VALUE_EN
  logic [11:0] digits_p0, digits_p1;

  assign digits_p0 = {y3_p0,
                      bits_to_digit(np_p0[2], nm_p0[2]),
                      bits_to_digit(np_p0[1], nm_p0[1]),
                      bits_to_digit(np_p0[0], nm_p0[0])};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits_p1 <= '0;
    end else if (in_valid) begin
      digits_p1 <= digits_p0;
    end
  end

  assign digits = digits_p1;
`endif

endmodule

// File: tb/tb_nr4sdp_recoder_unit.sv
// Directed-vector bench for nr4sdp_recoder_unit: hand-computed table, control corner cases,
// and a full sweep of a checking the digit-sum invariant and select/correction consistency.
module tb_nr4sdp_recoder_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic        out_valid;
  logic [2:0]  nm, np, one_p, one_m, two_p;
  logic        sign, one, two;
  logic [15:0] cor;
`ifdef NR4SDP_DIGIT_VALUE_EN
  logic [11:0] digits;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nr4sdp_recoder_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .out_valid (out_valid),
    .nm        (nm),
    .np        (np),
    .one_p     (one_p),
    .one_m     (one_m),
    .two_p     (two_p),
    .sign      (sign),
    .one       (one),
    .two       (two),
    .cor       (cor)
`ifdef NR4SDP_DIGIT_VALUE_EN
    ,
    .digits    (digits)
`endif
  );

  typedef struct {
    logic [7:0]  a;
    logic [2:0]  np, nm, one_p, one_m, two_p;
    logic        sign, one, two;
    logic [15:0] cor;
  } vec_t;

  vec_t vecs[13];

  logic [33:0] got;
  assign got = {np, nm, one_p, one_m, two_p, sign, one, two, cor};

  function automatic logic [33:0] pack_exp(input vec_t v);
    return {v.np, v.nm, v.one_p, v.one_m, v.two_p, v.sign, v.one, v.two, v.cor};
  endfunction

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic r, input logic v, input logic [7:0] val);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    a        = val;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{8'h5C, 3'b100, 3'b010, 3'b000, 3'b010, 3'b100, 1'b0, 1'b1, 1'b0, 16'h0004};
    vecs[1]  = '{8'h00, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{8'h80, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 16'h0040};
    vecs[3]  = '{8'hFF, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0001};
    vecs[4]  = '{8'h7F, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b1, 16'h0001};
    vecs[5]  = '{8'h01, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{8'h02, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[7]  = '{8'hC0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 16'h0040};
    vecs[8]  = '{8'h40, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[9]  = '{8'h2A, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{8'h15, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{8'h3F, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 1'b0, 1'b1, 1'b0, 16'h0001};
    vecs[12] = '{8'hB7, 3'b010, 3'b101, 3'b000, 3'b101, 3'b010, 1'b1, 1'b1, 1'b0, 16'h0051};

    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 8'h5C;

    // Reset with in_valid high: reset wins.
    step(1'b0, 1'b1, 8'h5C);
    step(1'b0, 1'b1, 8'h5C);
    check("reset_data", got, 34'h0);
    check("reset_valid", {33'h0, out_valid}, 34'h0);

    for (int i = 0; i < 13; i++) begin
      step(1'b1, 1'b1, vecs[i].a);
      check($sformatf("vec_%02h", vecs[i].a), got, pack_exp(vecs[i]));
      check($sformatf("vec_%02h_valid", vecs[i].a), {33'h0, out_valid}, 34'h1);
    end

    // in_valid low after a load: data holds, valid drops.
    step(1'b1, 1'b1, 8'hB7);
    step(1'b1, 1'b0, 8'h00);
    check("hold_data", got, pack_exp(vecs[12]));
    check("hold_valid", {33'h0, out_valid}, 34'h0);
    step(1'b1, 1'b0, 8'h80);
    check("hold_data_2", got, pack_exp(vecs[12]));

    // Mid-run reset after a load clears everything.
    step(1'b1, 1'b1, 8'h5C);
    step(1'b0, 1'b1, 8'h7F);
    check("midreset_data", got, 34'h0);
    check("midreset_valid", {33'h0, out_valid}, 34'h0);

    // Full sweep: digit sum equals signed a, select lines and cor derive from np/nm/MB bits.
    for (int v = 0; v < 256; v++) begin
      int sum, y3, yj;
      logic [2:0]  e_op, e_om, e_tp;
      logic [15:0] e_cor;
      step(1'b1, 1'b1, 8'(v));
      sum = 0;
      for (int j = 0; j < 3; j++) begin
        yj  = 2 * int'(np[j]) - int'(nm[j]);
        sum = sum + yj * (1 << (2 * j));
      end
      y3  = two ? 2 : (one ? 1 : 0);
      if (sign) y3 = -y3;
      sum = sum + 64 * y3;
      check($sformatf("sum_%02h", v), 34'(sum), 34'(int'($signed(8'(v)))));
      check($sformatf("mb_%02h", v), {31'h0, sign, one, two},
            {31'h0, sign & (one | two), one & ~two, two & ~one});
      e_op  = np & nm;
      e_om  = ~np & nm;
      e_tp  = np & ~nm;
      e_cor = 16'h0;
      e_cor[0] = e_om[0];
      e_cor[2] = e_om[1];
      e_cor[4] = e_om[2];
      e_cor[6] = sign & (one | two);
      check($sformatf("sel_%02h", v), {9'h0, one_p, one_m, two_p, cor},
            {9'h0, e_op, e_om, e_tp, e_cor});
`ifdef NR4SDP_DIGIT_VALUE_EN
      check($sformatf("digits_%02h", v), {22'h0, digits},
            {22'h0, 3'(y3), 3'(2 * int'(np[2]) - int'(nm[2])),
             3'(2 * int'(np[1]) - int'(nm[1])), 3'(2 * int'(np[0]) - int'(nm[0]))});
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nr4sdp_recoder_unit.md
Name: nr4sdp_recoder_unit

Overview:
- Registered NR4SD+ recoder front end for the 8x8 signed modified-Booth/NR4SD+ multiplier.
- Recodes the 8-bit two's-complement operand A into:
  - three low NR4SD+ digits in {-1,0,+1,+2};
  - one most-significant MB digit in {-2..+2}.
- Produces the per-digit partial-product select lines and the 16-bit negation-correction word COR.
- Feeds the pp generators and the final adder. Those blocks are outside this unit.

Parameters:
- None. Width is fixed at 8 bits (3 NR4SD+ digits + 1 MB digit).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  A is valid this cycle
- a  in  8  signed two's-complement operand to recode
- out_valid  out  1  outputs hold a fresh recoding
- nm  out  3  NR4SD+ negative bit n-_j, digits j=0..2
- np  out  3  NR4SD+ positive bit n+_j, digits j=0..2
- one_p  out  3  digit j == +1
- one_m  out  3  digit j == -1
- two_p  out  3  digit j == +2
- sign  out  1  MB digit 3 negative
- one  out  1  |MB digit 3| == 1
- two  out  1  |MB digit 3| == 2
- cor  out  16  correction word added to the partial-product sum

Behaviour:
- Clocking: single clock. Reset is synchronous and active-low: on a clk edge with rst_n=0, all outputs go to 0, including out_valid.
- Latency: 1 cycle.
  - On a clk edge with in_valid=1, all outputs are loaded from the combinational recoding of a.
  - out_valid is the registered in_valid.
  - With in_valid=0, data outputs hold their values and out_valid drops to 0.
- Recoding (combinational, with c_0=0). For j=0..2:
  - v_j = 2*a[2j+1] + a[2j] + c_j, in 0..4.
  - v=0 → y=0, c=0.
  - v=1 → y=+1, c=0.
  - v=2 → y=+2, c=0.
  - v=3 → y=-1, c=1.
  - v=4 → y=0, c=1.
  - c_{j+1} is the carry out of digit j.
- MSD: v_3 = -2*a[7] + a[6] + c_3, in -2..+2. It becomes y_3 directly.
- Invariant: y_0 + 4*y_1 + 16*y_2 + 64*y_3 == signed(a).
- NR4SD+ bit pair per digit, as (np_j, nm_j):
  - 0 → (0,0)
  - -1 → (0,1)
  - +2 → (1,0)
  - +1 → (1,1)
- Digit value equals 2*np_j - nm_j.
- Extra circuit per digit:
  - one_p = np & nm
  - one_m = ~np & nm
  - two_p = np & ~nm
- Exactly one, or none, of the three is high.
- MB outputs:
  - sign = (y_3 < 0)
  - one = (|y_3| == 1)
  - two = (|y_3| == 2)
  - y_3 = 0 gives sign=one=two=0. There is no negative zero.
- COR:
  - cor[2j] = one_m[j] for j=0..2.
  - cor[6] = sign & (one | two).
  - All other bits are 0.
  - Sign-extension handling belongs to the pp generators, not this unit.
- in_valid asserted during reset: reset wins.

Optional Feature:
- Macro NR4SDP_DIGIT_VALUE_EN.
- When defined, adds output digits (12 bits): four 3-bit two's-complement digit values {y_3,y_2,y_1,y_0}, y_0 in bits [2:0].
  - Registered with the other outputs.
  - Reset value 0.
- When undefined, the port and its logic are absent and behaviour is otherwise identical.

Decomposition:
- Package nr4sdp_pkg:
  - localparams N_BITS=8, N_DIGITS=3, COR_W=16;
  - typedef for the 3-bit signed digit;
  - function digit_to_bits.
- One natural sub-module: nr4sdp_digit_cell. It is combinational, instantiated 3 times: (a_hi, a_lo, c_in) → (np, nm, one_p, one_m, two_p, c_out).
- The MB MSD stage and the register stage stay in the top.

Test Plan:
- a=8'h5C (92), in_valid=1 → next cycle:
  - np=100, nm=010, one_p=000, one_m=010, two_p=100;
  - sign=0, one=1, two=0;
  - cor=16'h0004, out_valid=1.
- a=8'h00 → all digit and MB outputs 0, cor=16'h0000.
- a=8'h80 (-128) → np=nm=000, sign=1, one=0, two=1, cor=16'h0040.
- a=8'hFF (-1) → nm=001, np=000, one_m=001, sign=one=two=0, cor=16'h0001.
- a=8'h7F (127) → one_m=001, two=1, sign=0, cor=16'h0001.
- Control and invariant checks:
  - rst_n=0 with in_valid=1 → all outputs 0 next cycle.
  - in_valid=0 after a load → data outputs hold, out_valid=0.
  - Exhaustive sweep of all 256 values of a → the digit-sum invariant holds.
